// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: grant encoding, read-tag record and widths.
package vram_arb_pkg;

  localparam int VRAM_AW = 15;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {GNT_IDLE, GNT_ULA, GNT_CPU, GNT_DMA} grant_t;

  typedef struct packed {
    logic   vld;
    grant_t src;
  } rd_tag_t;

  function automatic logic is_read_for(input rd_tag_t t, input grant_t g);
    return t.vld && (t.src == g);
  endfunction

endpackage

// File: rtl/vram_arb_slot.sv
// One-entry request holder: captures a request on load, drops it on clear.
module vram_arb_slot
  import vram_arb_pkg::*;
#(
  parameter int AW = VRAM_AW
) (
  input  logic              clk_sys,
  input  logic              nRESET,
  input  logic              load,
  input  logic              clear,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_din,
  output logic              full,
  output logic              we,
  output logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] din
);

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (load) begin
      we   <= ld_we;
      addr <= ld_addr;
      din  <= ld_din;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: ULA > CPU > DMA with DMA aging, read latency 2.
// Optional Spectrum snow emulation when VRAM_ARB_SNOW_EN is defined (adds snow_ena).
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW           = VRAM_AW,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk_sys,
  input  logic              nRESET,
`ifdef VRAM_ARB_SNOW_EN
  input  logic              snow_ena,
`endif
  input  logic              ula_req,
  input  logic [AW-1:0]     ula_addr,
  output logic [DATA_W-1:0] ula_dout,
  output logic              ula_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_busy,
  input  logic              dma_valid,
  input  logic [AW-1:0]     dma_addr,
  input  logic [DATA_W-1:0] dma_din,
  output logic              dma_ready,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int               AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic              cpu_load, cpu_full, cpu_slot_we, cpu_done;
  logic [AW-1:0]     cpu_slot_addr;
  logic [DATA_W-1:0] cpu_slot_din;
  logic              dma_load, dma_full, dma_slot_we, dma_full_next;
  logic [AW-1:0]     dma_slot_addr;
  logic [DATA_W-1:0] dma_slot_din;
  logic [AGE_W-1:0]  age;
  logic [AW-1:0]     ula_eff;
  grant_t            gnt;
  rd_tag_t           tag_p0, tag_p1;

  vram_arb_slot #(.AW(AW)) u_cpu_slot (
    .clk_sys (clk_sys),
    .nRESET  (nRESET),
    .load    (cpu_load),
    .clear   (gnt == GNT_CPU),
    .ld_we   (cpu_we),
    .ld_addr (cpu_addr),
    .ld_din  (cpu_din),
    .full    (cpu_full),
    .we      (cpu_slot_we),
    .addr    (cpu_slot_addr),
    .din     (cpu_slot_din)
  );

  vram_arb_slot #(.AW(AW)) u_dma_slot (
    .clk_sys (clk_sys),
    .nRESET  (nRESET),
    .load    (dma_load),
    .clear   (gnt == GNT_DMA),
    .ld_we   (1'b1),
    .ld_addr (dma_addr),
    .ld_din  (dma_din),
    .full    (dma_full),
    .we      (dma_slot_we),
    .addr    (dma_slot_addr),
    .din     (dma_slot_din)
  );

  assign cpu_load      = cpu_req & ~cpu_busy;
  assign dma_load      = dma_valid & dma_ready;
  assign dma_full_next = dma_load | (dma_full & (gnt != GNT_DMA));
  // A CPU write finishes at its grant; a CPU read finishes when its tag leaves the pipe.
  assign cpu_done      = ((gnt == GNT_CPU) && cpu_slot_we) || is_read_for(tag_p1, GNT_CPU);

  always_comb begin
    if (ula_req)                         gnt = GNT_ULA;
    else if (cpu_full && (age < AGE_MAX)) gnt = GNT_CPU;
    else if (dma_full)                   gnt = GNT_DMA;
    else if (cpu_full)                   gnt = GNT_CPU;
    else                                 gnt = GNT_IDLE;
  end

`ifdef VRAM_ARB_SNOW_EN
  always_comb begin
    ula_eff = ula_addr;
    if (snow_ena && cpu_full) ula_eff[6:0] = cpu_slot_addr[6:0];
  end
`else
  assign ula_eff = ula_addr;
`endif

  // Stage p0 (E0): grant registered onto the RAM port
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      mem_we    <= 1'b0;
      tag_p0    <= '0;
      age       <= '0;
      cpu_busy  <= 1'b0;
      dma_ready <= 1'b0;
    end else begin
      case (gnt)
        GNT_CPU: mem_we <= cpu_slot_we;
        GNT_DMA: mem_we <= dma_slot_we;
        default: mem_we <= 1'b0;
      endcase
      tag_p0 <= '{vld: (gnt == GNT_ULA) || ((gnt == GNT_CPU) && !cpu_slot_we), src: gnt};
      if (gnt == GNT_DMA)                 age <= '0;
      else if (dma_full && (age < AGE_MAX)) age <= age + AGE_W'(1);
      if (cpu_load)      cpu_busy <= 1'b1;
      else if (cpu_done) cpu_busy <= 1'b0;
      dma_ready <= ~dma_full_next;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      case (gnt)
        GNT_ULA: mem_addr <= ula_eff;
        GNT_CPU: begin
          mem_addr <= cpu_slot_addr;
          mem_din  <= cpu_slot_din;
        end
        GNT_DMA: begin
          mem_addr <= dma_slot_addr;
          mem_din  <= dma_slot_din;
        end
        default: ;
      endcase
    end
  end

  // Stage p1 (E1): RAM samples the address, tag follows
  always_ff @(posedge clk_sys) begin
    if (!nRESET) tag_p1 <= '0;
    else         tag_p1 <= tag_p0;
  end

  // Stage p2 (E2): read data steered to its requester
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      ula_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      ula_dout  <= '0;
      cpu_dout  <= '0;
    end else begin
      ula_valid <= is_read_for(tag_p1, GNT_ULA);
      cpu_ack   <= cpu_done;
      if (is_read_for(tag_p1, GNT_ULA)) ula_dout <= mem_dout;
      if (is_read_for(tag_p1, GNT_CPU)) cpu_dout <= mem_dout;
    end
  end

endmodule
